trigger_detect: RTL

//  Trigger generator for the internal logic analyzer. Compares probed i_data against a masked

---
 rtl/trigger_detect_if.sv | 37 +++
 rtl/trigger_detect.sv | 114 +++++++++++
 2 files changed

// File: rtl/trigger_detect_if.sv
// Bus between the logic-analyzer control path and trigger_detect. The i_rise/i_fall
// edge selects exist only when TRIGGER_EDGE_EN is defined.
interface trigger_detect_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]  i_data;
    logic [DATA_WIDTH-1:0]  i_value;
    logic [DATA_WIDTH-1:0]  i_mask;
`ifdef TRIGGER_EDGE_EN
    logic [DATA_WIDTH-1:0]  i_rise;
    logic [DATA_WIDTH-1:0]  i_fall;
`endif
    logic [COUNT_WIDTH-1:0] i_count;
    logic                   i_arm;
    logic                   o_match;
    logic                   o_trigger;
    logic [COUNT_WIDTH-1:0] o_occurrences;

    modport master (
        output i_data, i_value, i_mask,
`ifdef TRIGGER_EDGE_EN
        output i_rise, i_fall,
`endif
        output i_count, i_arm,
        input  o_match, o_trigger, o_occurrences
    );

    modport slave (
        input  i_data, i_value, i_mask,
`ifdef TRIGGER_EDGE_EN
        input  i_rise, i_fall,
`endif
        input  i_count, i_arm,
        output o_match, o_trigger, o_occurrences
    );
endinterface

// File: rtl/trigger_detect.sv
// Logic-analyzer trigger: masked pattern match, occurrence counting while armed, sticky trigger.
// Define TRIGGER_EDGE_EN to add per-bit rising/falling edge qualifiers (i_rise/i_fall).
module trigger_detect #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    trigger_detect_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  data_q;
`ifdef TRIGGER_EDGE_EN
    logic [DATA_WIDTH-1:0]  prev_q;
    logic [DATA_WIDTH-1:0]  edgeSel;
    logic [DATA_WIDTH-1:0]  edgeQual;
`endif
    logic                   match_q;
    logic                   trigger_q;
    logic                   hist_q;
    logic [COUNT_WIDTH-1:0] occ_q;

    logic                   edgeOk;
    logic                   match_d;
    logic                   event_d;
    logic [COUNT_WIDTH-1:0] occInc_d;
    logic [COUNT_WIDTH-1:0] threshold;

    // With no edge selected the qualifier is transparent; otherwise any selected edge qualifies.
    always_comb begin
`ifdef TRIGGER_EDGE_EN
        edgeSel  = bus.i_rise | bus.i_fall;
        edgeQual = (bus.i_rise & ~prev_q & data_q) | (bus.i_fall & prev_q & ~data_q);
        edgeOk   = (edgeSel == '0) || (|edgeQual);
`else
        edgeOk   = 1'b1;
`endif
    end

    always_comb begin
        match_d   = (((data_q ^ bus.i_value) & bus.i_mask) == '0) && edgeOk;
        event_d   = match_d & ~hist_q;
        occInc_d  = (occ_q == '1) ? occ_q : occ_q + 1'b1;
        threshold = (bus.i_count == '0) ? {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : bus.i_count;
    end

    // hist_q stays clear outside ARMED so a match already present at arming counts once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
`ifdef TRIGGER_EDGE_EN
            prev_q    <= '0;
`endif
            match_q   <= 1'b0;
            trigger_q <= 1'b0;
            hist_q    <= 1'b0;
            occ_q     <= '0;
        end else begin
            data_q  <= bus.i_data;
`ifdef TRIGGER_EDGE_EN
            prev_q  <= data_q;
`endif
            match_q <= match_d;
            hist_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    trigger_q <= 1'b0;
                    occ_q     <= '0;
                    if (bus.i_arm) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!bus.i_arm) begin
                        state_q   <= IDLE;
                        trigger_q <= 1'b0;
                        occ_q     <= '0;
                    end else begin
                        hist_q <= match_d;
                        if (event_d) begin
                            occ_q <= occInc_d;
                            if (occInc_d >= threshold) begin
                                state_q   <= FIRED;
                                trigger_q <= 1'b1;
                            end
                        end
                    end
                end
                FIRED: begin
                    trigger_q <= 1'b1;
                    if (!bus.i_arm) begin
                        state_q   <= IDLE;
                        trigger_q <= 1'b0;
                        occ_q     <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    trigger_q <= 1'b0;
                    occ_q     <= '0;
                end
            endcase
        end
    end

    assign bus.o_match       = match_q;
    assign bus.o_trigger     = trigger_q;
    assign bus.o_occurrences = occ_q;

endmodule
